time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning base ticks per second (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, the 50 MHz system clock.
REQ-003 SHALL have port rst, input, 1, the reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port tick_in, input, 1, the divided clock from the clock divider, registered in the clk domain; each rising edge is one base tick.
REQ-005 SHALL have port btn_mode, input, 1, a single-cycle pulse from an upstream debouncer that advances the mode.
REQ-006 SHALL have port btn_inc, input, 1, a single-cycle pulse that increments the selected field.
REQ-007 SHALL have ports hour_t, hour_u, min_t, min_u, sec_t, sec_u, each output, 4, BCD digits of the time of day.
REQ-008 SHALL have port mode, output, 2, 00=RUN, 01=SET_HR, 10=SET_MIN; 11 is never driven.
REQ-009 SHALL have port sec_pulse, output, 1, a one-cycle pulse on each running seconds rollover.

Function
REQ-010 SHALL detect a tick as tick_in=1 AND tick_q=0, where tick_q is tick_in delayed one clk; no synchronizer SHALL be added, since tick_in is in the same clock domain.
REQ-011 SHALL keep a sub-second counter, 16 bits, 0..TICKS_PER_SEC-1, which increments on each tick in RUN and wraps to 0 at TICKS_PER_SEC-1, producing a seconds carry.
REQ-012 SHALL update the digits on the same clk edge at which tick_q captures 1, i.e. one cycle after tick_in rises.
REQ-013 SHALL count seconds and minutes BCD 00..59: the units digit wraps 9->0 and carries into tens; the tens digit wraps 5->0 on 59 and carries to the next field.
REQ-014 SHALL count hours BCD 00..23 and wrap 23->00; the hour carry SHALL be discarded.
REQ-015 SHALL assert sec_pulse for exactly one cycle, concurrent with the seconds digit update, in RUN only.
REQ-016 SHALL cycle the FSM RUN -> SET_HR -> SET_MIN -> RUN on each btn_mode pulse.
REQ-017 SHALL freeze the sub-second counter and the digits in SET_HR and SET_MIN, ignoring ticks.
REQ-018 SHALL, in SET_HR, increment hours by 1 on btn_inc, wrapping 23->00, with no carry into or out of other fields.
REQ-019 SHALL, in SET_MIN, increment minutes by 1 on btn_inc, wrapping 59->00, with no carry into hours.
REQ-020 SHALL ignore btn_inc in RUN.
REQ-021 SHALL, on the SET_MIN->RUN transition, clear seconds to 00 and the sub-second counter to 0 on the same edge.
REQ-022 SHALL give btn_mode priority when btn_mode and btn_inc are asserted in the same cycle: the mode advances and the inc is discarded.
REQ-023 SHALL apply a btn_mode pulse in RUN on the same edge as a tick, the tick being counted before the mode change takes effect.
REQ-024 SHALL never present a non-BCD digit or an out-of-range time at any output.

Reset
REQ-025 SHALL, while rst=0, force all digits to 0 (00:00:00), the sub-second counter to 0, tick_q to 0, mode to RUN and sec_pulse to 0, asynchronously.
REQ-026 SHALL resume counting on the first tick edge after rst deasserts; if tick_in=1 at release, that cycle counts as a tick edge.
REQ-027 SHALL, on reset mid-operation, including in a SET state, discard all state with no partial update.

Verification (TICKS_PER_SEC=4 in simulation)
REQ-028 Reset, then 4 tick_in rising edges -> sec_u=1 and sec_pulse high exactly one cycle, one clk after the 4th rising edge.
REQ-029 Preload 23:59:59 via SET, then 4 ticks -> 00:00:00 and a single sec_pulse.
REQ-030 btn_mode once, then btn_inc 25 times -> mode=01 and hours=01; ticks during this period leave the digits unchanged.
REQ-031 In SET_MIN at 59, btn_inc once -> min=00 with hours unchanged; btn_mode with 37 s displayed -> mode=00, sec=00, sub-second=0.
REQ-032 btn_mode and btn_inc in the same cycle from RUN -> mode=01 and all digits unchanged.
REQ-033 rst pulsed low for 1 cycle while in SET_MIN at 12:34 -> 00:00:00, mode=00 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/time_keeper_if.sv
//==============================================================================
// time_keeper_if : tick/button inputs and BCD time-of-day outputs
// Rev 1.0
//==============================================================================
`default_nettype none

interface time_keeper_if;
    logic       tick_in;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] hour_t;
    logic [3:0] hour_u;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [1:0] mode;
    logic       sec_pulse;

    modport master (
        output tick_in, btn_mode, btn_inc,
        input  hour_t, hour_u, min_t, min_u, sec_t, sec_u, mode, sec_pulse
    );

    modport slave (
        input  tick_in, btn_mode, btn_inc,
        output hour_t, hour_u, min_t, min_u, sec_t, sec_u, mode, sec_pulse
    );
endinterface

`default_nettype wire

// File: rtl/time_keeper.sv
//==============================================================================
// time_keeper : BCD 24-hour clock with RUN / SET_HR / SET_MIN modes
// Rev 1.0
//==============================================================================
`default_nettype none

module time_keeper #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    time_keeper_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

    localparam logic [15:0] SUB_MAX = 16'(TICKS_PER_SEC - 1);

    mode_e       mode_q, mode_d;
    logic        tick_q, tick_d;
    logic [15:0] sub_q, sub_d;
    logic [3:0]  hour_t_q, hour_t_d, hour_u_q, hour_u_d;
    logic [3:0]  min_t_q, min_t_d, min_u_q, min_u_d;
    logic [3:0]  sec_t_q, sec_t_d, sec_u_q, sec_u_d;
    logic        sec_pulse_q, sec_pulse_d;

    logic        tick_edge;
    logic        sec_carry;
    logic        min_carry;
    logic        hr_carry;

    // 00..59 BCD increment, returns {tens, units}
    function automatic logic [7:0] bcd60_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (u == 4'd9) begin
            r = (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
        end else begin
            r = {t, u + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd24_inc(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (t == 4'd2 && u == 4'd3) begin
            r = 8'h00;
        end else if (u == 4'd9) begin
            r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, u + 4'd1};
        end
        return r;
    endfunction

    assign tick_edge = bus.tick_in & ~tick_q;
    assign sec_carry = (mode_q == RUN) && tick_edge && (sub_q == SUB_MAX);
    assign min_carry = sec_carry && (sec_t_q == 4'd5) && (sec_u_q == 4'd9);
    assign hr_carry  = min_carry && (min_t_q == 4'd5) && (min_u_q == 4'd9);

    always_comb begin
        mode_d      = mode_q;
        tick_d      = bus.tick_in;
        sub_d       = sub_q;
        hour_t_d    = hour_t_q;
        hour_u_d    = hour_u_q;
        min_t_d     = min_t_q;
        min_u_d     = min_u_q;
        sec_t_d     = sec_t_q;
        sec_u_d     = sec_u_q;
        sec_pulse_d = 1'b0;

        unique case (mode_q)
            RUN: begin
                // The tick is counted even when btn_mode leaves RUN on this edge
                if (tick_edge) begin
                    sub_d = sec_carry ? 16'd0 : sub_q + 16'd1;
                end
                if (sec_carry) begin
                    sec_pulse_d        = 1'b1;
                    {sec_t_d, sec_u_d} = bcd60_inc(sec_t_q, sec_u_q);
                end
                if (min_carry) begin
                    {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
                end
                if (hr_carry) begin
                    {hour_t_d, hour_u_d} = bcd24_inc(hour_t_q, hour_u_q);
                end
                if (bus.btn_mode) begin
                    mode_d = SET_HR;
                end
            end
            SET_HR: begin
                if (bus.btn_mode) begin
                    mode_d = SET_MIN;
                end else if (bus.btn_inc) begin
                    {hour_t_d, hour_u_d} = bcd24_inc(hour_t_q, hour_u_q);
                end
            end
            SET_MIN: begin
                if (bus.btn_mode) begin
                    mode_d  = RUN;
                    sec_t_d = 4'd0;
                    sec_u_d = 4'd0;
                    sub_d   = 16'd0;
                end else if (bus.btn_inc) begin
                    {min_t_d, min_u_d} = bcd60_inc(min_t_q, min_u_q);
                end
            end
            default: begin
                mode_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= RUN;
            tick_q      <= 1'b0;
            sub_q       <= 16'd0;
            hour_t_q    <= 4'd0;
            hour_u_q    <= 4'd0;
            min_t_q     <= 4'd0;
            min_u_q     <= 4'd0;
            sec_t_q     <= 4'd0;
            sec_u_q     <= 4'd0;
            sec_pulse_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            sub_q       <= sub_d;
            hour_t_q    <= hour_t_d;
            hour_u_q    <= hour_u_d;
            min_t_q     <= min_t_d;
            min_u_q     <= min_u_d;
            sec_t_q     <= sec_t_d;
            sec_u_q     <= sec_u_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign bus.hour_t    = hour_t_q;
    assign bus.hour_u    = hour_u_q;
    assign bus.min_t     = min_t_q;
    assign bus.min_u     = min_u_q;
    assign bus.sec_t     = sec_t_q;
    assign bus.sec_u     = sec_u_q;
    assign bus.mode      = mode_q;
    assign bus.sec_pulse = sec_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
//==============================================================================
// tb_time_keeper : directed stimulus against a seconds-of-day reference model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_time_keeper;

    localparam int TPS = 4;

    logic clk;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   pulse_cnt = 0;

    time_keeper_if tk_if ();

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tk_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: time held as plain hours/minutes/seconds integers
    int m_h = 0, m_m = 0, m_s = 0, m_sub = 0, m_mode = 0;
    bit m_pulse = 0, m_prev = 0, m_tk;
    int m_tot;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_sub = 0; m_mode = 0;
            m_pulse = 0; m_prev = 0;
        end else begin
            m_tk    = tk_if.tick_in && !m_prev;
            m_prev  = tk_if.tick_in;
            m_pulse = 0;
            case (m_mode)
                0: begin
                    if (m_tk) begin
                        m_sub = m_sub + 1;
                        if (m_sub == TPS) begin
                            m_sub   = 0;
                            m_pulse = 1;
                            m_tot   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                            m_h     = m_tot / 3600;
                            m_m     = (m_tot / 60) % 60;
                            m_s     = m_tot % 60;
                        end
                    end
                    if (tk_if.btn_mode) m_mode = 1;
                end
                1: begin
                    if (tk_if.btn_mode)     m_mode = 2;
                    else if (tk_if.btn_inc) m_h = (m_h + 1) % 24;
                end
                default: begin
                    if (tk_if.btn_mode) begin
                        m_mode = 0; m_s = 0; m_sub = 0;
                    end else if (tk_if.btn_inc) begin
                        m_m = (m_m + 1) % 60;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int dut_h(); return tk_if.hour_t * 10 + tk_if.hour_u; endfunction
    function automatic int dut_m(); return tk_if.min_t * 10 + tk_if.min_u; endfunction
    function automatic int dut_s(); return tk_if.sec_t * 10 + tk_if.sec_u; endfunction

    always @(negedge clk) begin
        if (tk_if.sec_pulse) pulse_cnt++;
        check("cyc_hour_t", int'(tk_if.hour_t), m_h / 10);
        check("cyc_hour_u", int'(tk_if.hour_u), m_h % 10);
        check("cyc_min_t",  int'(tk_if.min_t),  m_m / 10);
        check("cyc_min_u",  int'(tk_if.min_u),  m_m % 10);
        check("cyc_sec_t",  int'(tk_if.sec_t),  m_s / 10);
        check("cyc_sec_u",  int'(tk_if.sec_u),  m_s % 10);
        check("cyc_mode",   int'(tk_if.mode),   m_mode);
        check("cyc_pulse",  int'(tk_if.sec_pulse), int'(m_pulse));
    end

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hr"},  dut_h(), h);
        check({tag, "_min"}, dut_m(), m);
        check({tag, "_sec"}, dut_s(), s);
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            tk_if.tick_in = 1'b1;
            @(negedge clk);
            tk_if.tick_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic m, input logic i, input int n);
        repeat (n) begin
            tk_if.btn_mode = m;
            tk_if.btn_inc  = i;
            @(negedge clk);
            tk_if.btn_mode = 1'b0;
            tk_if.btn_inc  = 1'b0;
            @(negedge clk);
        end
    endtask

    int base;

    initial begin
        tk_if.tick_in  = 1'b0;
        tk_if.btn_mode = 1'b0;
        tk_if.btn_inc  = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_time("reset", 0, 0, 0);
        check("reset_mode", int'(tk_if.mode), 0);
        rst = 1'b1;
        @(negedge clk);

        // First second after reset; pulse lands one clk after 4th rising edge
        base = pulse_cnt;
        do_tick(3);
        check("pre_sec_u", int'(tk_if.sec_u), 0);
        tk_if.tick_in = 1'b1;
        @(negedge clk);
        check("sec_u_after4", int'(tk_if.sec_u), 1);
        check("pulse_high", int'(tk_if.sec_pulse), 1);
        tk_if.tick_in = 1'b0;
        @(negedge clk);
        check("pulse_low", int'(tk_if.sec_pulse), 0);
        check("pulse_count1", pulse_cnt - base, 1);

        // mode+inc together: mode wins, digits untouched
        press(1'b1, 1'b1, 1);
        check("both_mode", int'(tk_if.mode), 1);
        check_time("both", 0, 0, 1);

        // 25 increments in SET_HR with ticks interleaved
        repeat (25) begin
            press(1'b0, 1'b1, 1);
            do_tick(1);
        end
        check("sethr_mode", int'(tk_if.mode), 1);
        check_time("sethr25", 1, 0, 1);
        press(1'b1, 1'b0, 2);
        check_time("back_run", 1, 0, 0);

        // 37 s plus 2 sub-ticks, then minute wrap in SET_MIN
        do_tick(37 * TPS + 2);
        check_time("run37", 1, 0, 37);
        press(1'b1, 1'b0, 2);
        check("setmin_mode", int'(tk_if.mode), 2);
        press(1'b0, 1'b1, 59);
        check_time("min59", 1, 59, 37);
        press(1'b0, 1'b1, 1);
        check_time("minwrap", 1, 0, 37);
        press(1'b1, 1'b0, 1);
        check("exit_mode", int'(tk_if.mode), 0);
        check_time("exit_clr", 1, 0, 0);
        do_tick(TPS - 1);
        check("subclr_sec", dut_s(), 0);
        do_tick(1);
        check("subclr_sec1", dut_s(), 1);

        // Tick and btn_mode on the same edge
        tk_if.tick_in  = 1'b1;
        tk_if.btn_mode = 1'b1;
        @(negedge clk);
        tk_if.tick_in  = 1'b0;
        tk_if.btn_mode = 1'b0;
        @(negedge clk);
        check("tickmode_mode", int'(tk_if.mode), 1);

        // Preload 23:59:59 and roll over midnight
        press(1'b0, 1'b1, 22);
        check("hr23", dut_h(), 23);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 59);
        press(1'b1, 1'b0, 1);
        check_time("pre_mid", 23, 59, 0);
        do_tick(59 * TPS);
        check_time("t235959", 23, 59, 59);
        base = pulse_cnt;
        do_tick(TPS);
        check_time("midnight", 0, 0, 0);
        check("mid_pulses", pulse_cnt - base, 1);

        // Async reset while in SET_MIN at 12:34
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 12);
        press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 34);
        check_time("set1234", 12, 34, 0);
        check("set1234_mode", int'(tk_if.mode), 2);
        #5 rst = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_mode", int'(tk_if.mode), 0);
        tk_if.tick_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tk_if.tick_in = 1'b0;
        @(negedge clk);
        do_tick(TPS - 1);
        check("rel_tick_sec", dut_s(), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
